serial_add_ctrl: RTL
====================

# serial_add_ctrl

Bit-serial addition controller that time-shares one `fulladder` cell across a WIDTH-bit add. Operands are loaded on a start request and fed through the cell one bit per clock, LSB first, with the carry held in a flip-flop between cycles. The block sits between a register-file/operand source and any consumer that needs a multi-bit sum but can only afford a single 1-bit adder.

## Interface

- `WIDTH`, default 8: operand and sum width in bits; legal range 2..32.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request to begin an add; honoured only in IDLE.
- `a`  in  WIDTH: operand A; sampled on the accepting edge.
- `b`  in  WIDTH: operand B; sampled on the accepting edge.
- `cin`  in  1: carry-in; sampled on the accepting edge.
- `busy`  out  1: high while bits are being processed (RUN).
- `done`  out  1: single-cycle pulse; `sum` and `cout` are final.
- `sum`  out  WIDTH: result; holds its value until the next accepted start.
- `cout`  out  1: final carry-out; holds like `sum`.
- `ovf`  out  1: signed overflow; present only with `SERIAL_ADD_OVF_EN`.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE: on an edge with `start=1`, load `a` and `b` into their shift registers, set the carry flop to `cin`, clear the bit counter, and go to RUN. `start=0` keeps the FSM in IDLE.
- RUN: on every edge:
  - drive the `fulladder` inputs with a_sr[0], b_sr[0] and the carry flop;
  - shift the cell's `s` into the sum shift register at the MSB, shifting right;
  - shift a_sr and b_sr right by one;
  - load the carry flop from the cell's `cout`;
  - increment the counter.
- RUN exits to DONE on the edge where the counter equals WIDTH-1 (the last bit). On that edge, `cout` is loaded from the cell's carry-out.
- DONE: `done=1`. The FSM goes to IDLE on the next edge unconditionally.
- `start` in RUN or DONE is ignored. It is not queued.
- `a`, `b` and `cin` changing after acceptance have no effect.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
- Counter width is $clog2(WIDTH). It never wraps past WIDTH-1.

## Timing

- Reset (asynchronous, any state): FSM goes to IDLE. All shift registers, the counter, the carry flop, `sum`, `cout` and `ovf` go to 0. `busy` and `done` go to 0.
- Reset mid-RUN aborts the add. No `done` is produced.
- Edge numbering: E0 is the accepting edge.
  - `busy` is high from after E0 through E_WIDTH.
  - `done` is high for exactly one cycle, after E_WIDTH.
  - Latency from the start edge to `done` is WIDTH cycles. Issue rate is at most one add per WIDTH+2 cycles.
- `sum`/`cout` are valid from the `done` cycle until the edge after the next accepted start.
- `busy` and `done` are never high together.
- All outputs are registered, or decoded directly from state. There is no combinational path from inputs to outputs.

## Configuration

- `SERIAL_ADD_OVF_EN` defined:
  - adds the `ovf` port;
  - on the final RUN edge, `ovf` is loaded with (carry into the MSB) XOR (carry out of the MSB);
  - `ovf` holds and resets like `cout`.
- Not defined: no `ovf` port, no extra logic.

## Structure

- Shared package `serial_add_pkg`:
  - FSM state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the default-WIDTH constant.
- Sub-module: one instance of the existing `fulladder`, with port order (cout, s, x, y, cin). No other sub-modules.

## Test plan

- WIDTH=8, a=0x3C, b=0x0F, cin=0, start pulsed one cycle -> `busy` for 8 cycles, then `done` pulse; sum=0x4B, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Start accepted with a=0x11, b=0x22. `start` held high, a=0xAA, b=0x55 applied during RUN and DONE -> sum=0x33, no second add begins, `done` pulses once.
- `rst_n` low for one cycle at RUN bit 4 -> `busy`=0, sum=0, cout=0 immediately, no `done`. The next start with 0x01+0x01 gives 0x02.
- Exhaustive sweep: WIDTH=4, all 512 (a,b,cin) combinations back-to-back -> {cout,sum} equals a+b+cin each time, with exactly one `done` per start.
- With `SERIAL_ADD_OVF_EN`, WIDTH=8:
  - 0x7F+0x01 -> ovf=1, sum=0x80;
  - 0x80+0xFF -> ovf=1, cout=1;
  - 0x05+0x03 -> ovf=0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and
// the default operand width.
package serial_add_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_fulladder.sv
// Single-bit full adder cell, time-shared by the serial add controller.
module fulladder (
   output logic cout,
   output logic s,
   input  logic x,
   input  logic y,
   input  logic cin
);

   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one fulladder cell, LSB first, carry in a flop.
// Defining SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_co;

   fulladder u_fa (
      .cout (fa_co),
      .s    (fa_s),
      .x    (a_sr[0]),
      .y    (b_sr[0]),
      .cin  (carry)
   );

   // Status is decoded straight from the state register, so no input reaches
   // an output combinationally.
   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               sum   <= {fa_s, sum[WIDTH-1:1]};
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               carry <= fa_co;
               if (cnt == LAST) begin
                  cout  <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                  // carry still holds the carry into the MSB on this edge
                  ovf   <= carry ^ fa_co;
`endif
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
